// File: rtl/bus_ic_pkg.sv
// Shared types and default address map for the rv32 two-master bus interconnect.
// The optional watchdog is enabled with the BUS_IC_TIMEOUT_EN macro.
package bus_ic_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} tsize_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    ERR   = 2'd3
  } bus_ic_state_e;

  localparam int NS_DEF = 3;

  // Slave 0 is ROM, slave 1 is RAM, slave 2 is peripherals.
  localparam logic [NS_DEF-1:0][31:0] SLV_BASE_DEF = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NS_DEF-1:0][31:0] SLV_MASK_DEF = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
endpackage

// File: rtl/bus_ic_if.sv
// Master and slave side bus interfaces; the interconnect connects through the ic modports.
// Handshake: owner pulses bstart with addr/tsize/wdata; the response is one cycle of bdone or berror with rdata.
interface master_bus_if;
  import bus_ic_pkg::*;
  logic        breq;
  logic        bgnt;
  logic        bstart;
  logic [31:0] addr;
  tsize_e      tsize;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;
  logic        berror;
  modport ic  (input breq, bstart, addr, tsize, wdata, output bgnt, rdata, bdone, berror);
  modport mst (output breq, bstart, addr, tsize, wdata, input bgnt, rdata, bdone, berror);
endinterface

interface slave_bus_if;
  import bus_ic_pkg::*;
  logic        bstart;
  logic        ss;
  logic [31:0] addr;
  tsize_e      tsize;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;
  logic        berror;
  modport ic  (output bstart, ss, addr, tsize, wdata, input rdata, bdone, berror);
  modport slv (input bstart, ss, addr, tsize, wdata, output rdata, bdone, berror);
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: returns hit and the index of the lowest-numbered matching slave.
module bus_addr_decode
  import bus_ic_pkg::*;
#(
  parameter int                      NS       = NS_DEF,
  parameter int                      SW       = 2,
  parameter logic [NS-1:0][31:0]     SLV_BASE = SLV_BASE_DEF,
  parameter logic [NS-1:0][31:0]     SLV_MASK = SLV_MASK_DEF
) (
  input  logic [31:0]   i_addr,
  output logic          o_hit,
  output logic [SW-1:0] o_idx
);
  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((i_addr & SLV_MASK[i]) == SLV_BASE[i]) begin
        o_hit = 1'b1;
        o_idx = SW'(i);
      end
    end
  end
endmodule

// File: rtl/bus_interconnect.sv
// Two-master shared-bus controller: round-robin arbitration, address decode, response routing.
// Define BUS_IC_TIMEOUT_EN to add a watchdog that errors out slaves silent for TIMEOUT_CYCLES.
module bus_interconnect
  import bus_ic_pkg::*;
#(
  parameter int                  NM             = 2,
  parameter int                  NS             = NS_DEF,
  parameter logic [NS-1:0][31:0] SLV_BASE       = SLV_BASE_DEF,
  parameter logic [NS-1:0][31:0] SLV_MASK       = SLV_MASK_DEF,
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic          bclk,
  input  logic          brst_n,
  master_bus_if.ic      m [NM],
  slave_bus_if.ic       s [NS],
  output bus_ic_state_e o_state
);
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  logic [NM-1:0] w_breq, w_bstart, w_m_bdone, w_m_berror;
  logic [31:0]   w_m_addr [NM];
  logic [31:0]   w_m_wdata [NM];
  tsize_e        w_m_tsize [NM];
  logic [31:0]   w_m_rdata [NM];

  logic [NS-1:0] w_s_bdone, w_s_berror, w_s_bstart, w_s_ss;
  logic [31:0]   w_s_rdata [NS];
  logic [31:0]   w_s_addr [NS];
  logic [31:0]   w_s_wdata [NS];
  tsize_e        w_s_tsize [NS];

  bus_ic_state_e r_state;
  logic          r_owner, r_prio;
  logic [NM-1:0] r_gnt;
  logic [SW-1:0] r_sel;
  logic [31:0]   r_addr, r_wdata;
  tsize_e        r_tsize;

  logic          w_own_breq, w_own_bstart, w_win, w_hit, w_fwd, w_resp, w_timeout;
  logic          w_sel_bdone, w_sel_berror;
  logic [31:0]   w_own_addr, w_sel_rdata;
  logic [SW-1:0] w_dec_idx;

  for (genvar g = 0; g < NM; g++) begin : g_mst
    assign w_breq[g]    = m[g].breq;
    assign w_bstart[g]  = m[g].bstart;
    assign w_m_addr[g]  = m[g].addr;
    assign w_m_wdata[g] = m[g].wdata;
    assign w_m_tsize[g] = m[g].tsize;
    assign m[g].bgnt    = r_gnt[g];
    assign m[g].bdone   = w_m_bdone[g];
    assign m[g].berror  = w_m_berror[g];
    assign m[g].rdata   = w_m_rdata[g];
  end

  for (genvar g = 0; g < NS; g++) begin : g_slv
    assign w_s_bdone[g]  = s[g].bdone;
    assign w_s_berror[g] = s[g].berror;
    assign w_s_rdata[g]  = s[g].rdata;
    assign s[g].bstart   = w_s_bstart[g];
    assign s[g].ss       = w_s_ss[g];
    assign s[g].addr     = w_s_addr[g];
    assign s[g].wdata    = w_s_wdata[g];
    assign s[g].tsize    = w_s_tsize[g];
  end

  assign w_own_breq   = w_breq[r_owner];
  assign w_own_bstart = w_bstart[r_owner];
  assign w_own_addr   = w_m_addr[r_owner];
  assign w_win        = w_breq[r_prio] ? r_prio : ~r_prio;

  bus_addr_decode #(.NS(NS), .SW(SW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_dec (
    .i_addr (w_own_addr),
    .o_hit  (w_hit),
    .o_idx  (w_dec_idx)
  );

  always_comb begin
    w_sel_bdone  = 1'b0;
    w_sel_berror = 1'b0;
    w_sel_rdata  = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_sel == SW'(i)) begin
        w_sel_bdone  = w_s_bdone[i];
        w_sel_berror = w_s_berror[i];
        w_sel_rdata  = w_s_rdata[i];
      end
    end
  end

  assign w_fwd  = (r_state == GRANT) && w_own_breq && w_own_bstart && w_hit;
  assign w_resp = (r_state == BUSY) && (w_sel_bdone || w_sel_berror);

`ifdef BUS_IC_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n)               r_cnt <= '0;
    else if (r_state != BUSY)  r_cnt <= '0;
    else                       r_cnt <= r_cnt + 16'd1;
  end
  // A real response in the timeout cycle takes precedence.
  assign w_timeout = (r_state == BUSY) && (r_cnt == 16'(TIMEOUT_CYCLES)) && !w_resp;
`else
  assign w_timeout = 1'b0;
  wire [31:0] w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tsize <= BYTE;
    end else begin
      case (r_state)
        IDLE: if (|w_breq) begin
          r_owner <= w_win;
          r_prio  <= ~w_win;
          r_gnt   <= NM'(1) << w_win;
          r_state <= GRANT;
        end
        GRANT: if (!w_own_breq) begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end else if (w_own_bstart) begin
          if (w_hit) begin
            r_sel   <= w_dec_idx;
            r_addr  <= w_own_addr;
            r_wdata <= w_m_wdata[r_owner];
            r_tsize <= w_m_tsize[r_owner];
            r_state <= BUSY;
          end else begin
            r_state <= ERR;
          end
        end
        BUSY: if (w_resp || w_timeout) r_state <= GRANT;
        default: r_state <= GRANT;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      w_m_bdone[i]  = 1'b0;
      w_m_berror[i] = 1'b0;
      w_m_rdata[i]  = '0;
      if (r_owner == 1'(i)) begin
        if (r_state == BUSY) begin
          w_m_bdone[i]  = w_sel_bdone;
          w_m_berror[i] = w_sel_berror || w_timeout;
          if (w_resp) w_m_rdata[i] = w_sel_rdata;
        end else if (r_state == ERR) begin
          w_m_berror[i] = 1'b1;
        end
      end
    end
  end

  // The decoded slave sees the live request in the bstart cycle, then the latched copy.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      w_s_bstart[i] = 1'b0;
      w_s_ss[i]     = 1'b0;
      w_s_addr[i]   = '0;
      w_s_wdata[i]  = '0;
      w_s_tsize[i]  = BYTE;
      if (w_fwd && (w_dec_idx == SW'(i))) begin
        w_s_bstart[i] = 1'b1;
        w_s_ss[i]     = 1'b1;
        w_s_addr[i]   = w_own_addr;
        w_s_wdata[i]  = w_m_wdata[r_owner];
        w_s_tsize[i]  = w_m_tsize[r_owner];
      end else if ((r_state == BUSY) && (r_sel == SW'(i))) begin
        w_s_ss[i]     = 1'b1;
        w_s_addr[i]   = r_addr;
        w_s_wdata[i]  = r_wdata;
        w_s_tsize[i]  = r_tsize;
      end
    end
  end

  assign o_state = r_state;
endmodule

// File: tb/tb_bus_interconnect.sv
// Directed plus randomized bench for bus_interconnect with a reference arbitration/decode model.
module tb_bus_interconnect;
  import bus_ic_pkg::*;

  // clock / reset
  logic bclk = 1'b0;
  logic brst_n;
  always #5 bclk = ~bclk;

  master_bus_if m_if [2] ();
  slave_bus_if  s_if [3] ();
  bus_ic_state_e dbg_state;

  bus_interconnect #(.NM(2), .NS(3), .TIMEOUT_CYCLES(8)) dut (
    .bclk    (bclk),
    .brst_n  (brst_n),
    .m       (m_if),
    .s       (s_if),
    .o_state (dbg_state)
  );

  logic        tb_breq [2];
  logic        tb_bstart [2];
  logic [31:0] tb_addr [2];
  logic [31:0] tb_wdata [2];
  tsize_e      tb_tsize [2];
  logic        ob_bgnt [2];
  logic        ob_bdone [2];
  logic        ob_berror [2];
  logic [31:0] ob_rdata [2];

  logic        sd_bdone [3];
  logic        sd_berror [3];
  logic [31:0] sd_rdata [3];
  logic        os_bstart [3];
  logic        os_ss [3];
  logic [31:0] os_addr [3];
  logic [31:0] os_wdata [3];
  tsize_e      os_tsize [3];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign m_if[g].breq   = tb_breq[g];
    assign m_if[g].bstart = tb_bstart[g];
    assign m_if[g].addr   = tb_addr[g];
    assign m_if[g].wdata  = tb_wdata[g];
    assign m_if[g].tsize  = tb_tsize[g];
    assign ob_bgnt[g]     = m_if[g].bgnt;
    assign ob_bdone[g]    = m_if[g].bdone;
    assign ob_berror[g]   = m_if[g].berror;
    assign ob_rdata[g]    = m_if[g].rdata;
  end

  for (genvar g = 0; g < 3; g++) begin : g_s
    assign s_if[g].bdone  = sd_bdone[g];
    assign s_if[g].berror = sd_berror[g];
    assign s_if[g].rdata  = sd_rdata[g];
    assign os_bstart[g]   = s_if[g].bstart;
    assign os_ss[g]       = s_if[g].ss;
    assign os_addr[g]     = s_if[g].addr;
    assign os_wdata[g]    = s_if[g].wdata;
    assign os_tsize[g]    = s_if[g].tsize;
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  int prio  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: address map from the top nibble
  function automatic int ref_slave(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'h2:    return 1;
      4'h4:    return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] gen_addr();
    logic [31:0] low;
    int r;
    low = $urandom & 32'h0FFF_FFFF;
    r = $urandom_range(0, 4);
    case (r)
      0:       return {4'h0, low[27:0]};
      1:       return {4'h2, low[27:0]};
      2:       return {4'h4, low[27:0]};
      3:       return {4'h3, low[27:0]};
      default: return {4'h8 | 4'($urandom_range(0, 7)), low[27:0]};
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic settle();
    @(negedge bclk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      tb_breq[i] = 1'b0; tb_bstart[i] = 1'b0; tb_addr[i] = '0; tb_wdata[i] = '0; tb_tsize[i] = BYTE;
    end
    for (int i = 0; i < 3; i++) begin
      sd_bdone[i] = 1'b0; sd_berror[i] = 1'b0; sd_rdata[i] = '0;
    end
  endtask

  task automatic noise(input int own);
    tb_bstart[1-own] = 1'($urandom_range(0, 1));
    tb_addr[1-own]   = $urandom;
    for (int i = 0; i < 3; i++) sd_rdata[i] = $urandom;
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_m%0d_bgnt", tag, i), 32'(ob_bgnt[i]), 32'd0);
      chk($sformatf("%s_m%0d_bdone", tag, i), 32'(ob_bdone[i]), 32'd0);
      chk($sformatf("%s_m%0d_berror", tag, i), 32'(ob_berror[i]), 32'd0);
      chk($sformatf("%s_m%0d_rdata", tag, i), ob_rdata[i], 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_s%0d_bstart", tag, i), 32'(os_bstart[i]), 32'd0);
      chk($sformatf("%s_s%0d_ss", tag, i), 32'(os_ss[i]), 32'd0);
      chk($sformatf("%s_s%0d_addr", tag, i), os_addr[i], 32'd0);
      chk($sformatf("%s_s%0d_wdata", tag, i), os_wdata[i], 32'd0);
      chk($sformatf("%s_s%0d_tsize", tag, i), 32'(os_tsize[i]), 32'(BYTE));
    end
  endtask

  // One transaction by the current owner, starting in a GRANT cycle; returns at a cycle start.
  task automatic do_txn(input int own);
    logic [31:0] a, wd, rd;
    tsize_e ts;
    logic err;
    int k, lat;
    a = gen_addr(); wd = $urandom; ts = tsize_e'($urandom_range(0, 2)); k = ref_slave(a);
    tb_bstart[own] = 1'b1; tb_addr[own] = a; tb_wdata[own] = wd; tb_tsize[own] = ts;
    noise(own);
    settle();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("txn_s%0d_bstart", j), 32'(os_bstart[j]), 32'(j == k));
      chk($sformatf("txn_s%0d_ss", j), 32'(os_ss[j]), 32'(j == k));
    end
    if (k >= 0) begin
      chk("txn_fwd_addr", os_addr[k], a);
      chk("txn_fwd_wdata", os_wdata[k], wd);
      chk("txn_fwd_tsize", 32'(os_tsize[k]), 32'(ts));
    end
    tick();
    tb_bstart[own] = 1'b0; tb_addr[own] = $urandom; tb_wdata[own] = $urandom;
    noise(own);
    if (k < 0) begin
      settle();
      chk("unm_berror", 32'(ob_berror[own]), 32'd1);
      chk("unm_bdone", 32'(ob_bdone[own]), 32'd0);
      chk("unm_rdata", ob_rdata[own], 32'd0);
      tick();
    end else begin
      rd = $urandom; err = ($urandom_range(0, 3) == 0);
      exp_q.push_back(rd);
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        settle();
        chk("busy_ss", 32'(os_ss[k]), 32'd1);
        chk("busy_bstart", 32'(os_bstart[k]), 32'd0);
        chk("busy_addr", os_addr[k], a);
        chk("busy_wdata", os_wdata[k], wd);
        chk("busy_bdone", 32'(ob_bdone[own]), 32'd0);
        tick();
        noise(own);
      end
      sd_bdone[k] = !err; sd_berror[k] = err; sd_rdata[k] = rd;
      settle();
      chk("rsp_bdone", 32'(ob_bdone[own]), 32'(!err));
      chk("rsp_berror", 32'(ob_berror[own]), 32'(err));
      chk("rsp_rdata", ob_rdata[own], exp_q.pop_front());
      chk("rsp_other_bdone", 32'(ob_bdone[1-own]), 32'd0);
      tick();
      sd_bdone[k] = 1'b0; sd_berror[k] = 1'b0;
    end
  endtask

  task automatic do_round();
    int mask, win, n;
    mask = $urandom_range(1, 3);
    tb_breq[0] = ((mask & 1) != 0);
    tb_breq[1] = ((mask & 2) != 0);
    win = (mask == 3) ? prio : ((mask == 1) ? 0 : 1);
    prio = 1 - win;
    tick();
    settle();
    chk("rr_win_bgnt", 32'(ob_bgnt[win]), 32'd1);
    chk("rr_lose_bgnt", 32'(ob_bgnt[1-win]), 32'd0);
    tick();
    n = $urandom_range(1, 3);
    repeat (n) do_txn(win);
    tb_breq[0] = 1'b0; tb_breq[1] = 1'b0; tb_bstart[0] = 1'b0; tb_bstart[1] = 1'b0;
    settle();
    chk("rr_hold_bgnt", 32'(ob_bgnt[win]), 32'd1);
    tick();
    settle();
    chk("rr_rel_bgnt0", 32'(ob_bgnt[0]), 32'd0);
    chk("rr_rel_bgnt1", 32'(ob_bgnt[1]), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] rd;
    clear_inputs();
    brst_n = 1'b0;
    settle();
    chk_quiet("reset");
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    brst_n = 1'b1;
    tick();

    // arbitration after reset and handover
    tb_breq[0] = 1'b1; tb_breq[1] = 1'b1;
    settle();
    chk("arb_pre_bgnt0", 32'(ob_bgnt[0]), 32'd0);
    tick(); settle();
    chk("arb_bgnt0", 32'(ob_bgnt[0]), 32'd1);
    chk("arb_bgnt1", 32'(ob_bgnt[1]), 32'd0);
    prio = 1;
    tb_breq[0] = 1'b0;
    tick(); settle();
    chk("hand_dead_bgnt0", 32'(ob_bgnt[0]), 32'd0);
    chk("hand_dead_bgnt1", 32'(ob_bgnt[1]), 32'd0);
    tick(); settle();
    chk("hand_bgnt1", 32'(ob_bgnt[1]), 32'd1);
    prio = 0;
    tick();

    // unmapped access from m1
    tb_bstart[1] = 1'b1; tb_addr[1] = 32'h8000_0000;
    settle();
    for (int j = 0; j < 3; j++) chk($sformatf("unm_s%0d_bstart", j), 32'(os_bstart[j]), 32'd0);
    chk("unm_same_cycle_berror", 32'(ob_berror[1]), 32'd0);
    tick();
    tb_bstart[1] = 1'b0;
    settle();
    chk("unm_m1_berror", 32'(ob_berror[1]), 32'd1);
    chk("unm_m1_rdata", ob_rdata[1], 32'd0);
    tick(); settle();
    chk("unm_m1_berror_end", 32'(ob_berror[1]), 32'd0);
    chk("unm_m1_bgnt", 32'(ob_bgnt[1]), 32'd1);
    tb_breq[1] = 1'b0;
    tick(); settle();
    chk("unm_release", 32'(ob_bgnt[1]), 32'd0);
    tick();

    // RAM word access from m0 with three-cycle latency
    tb_breq[0] = 1'b1;
    tick();
    prio = 1;
    tick();
    tb_bstart[0] = 1'b1; tb_addr[0] = 32'h2000_0010; tb_tsize[0] = WORD; tb_wdata[0] = 32'h1234_5678;
    settle();
    chk("ram_s1_bstart", 32'(os_bstart[1]), 32'd1);
    chk("ram_s1_ss", 32'(os_ss[1]), 32'd1);
    chk("ram_s1_addr", os_addr[1], 32'h2000_0010);
    chk("ram_s1_tsize", 32'(os_tsize[1]), 32'(WORD));
    chk("ram_s0_ss", 32'(os_ss[0]), 32'd0);
    chk("ram_s2_ss", 32'(os_ss[2]), 32'd0);
    tick();
    tb_bstart[0] = 1'b0; tb_addr[0] = 32'h4000_0000; tb_wdata[0] = 32'h0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("ram_wait_bstart", 32'(os_bstart[1]), 32'd0);
      chk("ram_wait_addr", os_addr[1], 32'h2000_0010);
      chk("ram_wait_wdata", os_wdata[1], 32'h1234_5678);
      chk("ram_wait_s2_ss", 32'(os_ss[2]), 32'd0);
      tick();
    end
    sd_bdone[1] = 1'b1; sd_rdata[1] = 32'hDEAD_BEEF;
    settle();
    chk("ram_m0_bdone", 32'(ob_bdone[0]), 32'd1);
    chk("ram_m0_rdata", ob_rdata[0], 32'hDEAD_BEEF);
    tick();
    sd_bdone[1] = 1'b0;
    settle();
    chk("ram_ss_drop", 32'(os_ss[1]), 32'd0);
    chk("ram_bdone_drop", 32'(ob_bdone[0]), 32'd0);
    tick();

    // owner drops breq while busy
    tb_bstart[0] = 1'b1; tb_addr[0] = 32'h0000_0100; tb_tsize[0] = HALF;
    tick();
    tb_bstart[0] = 1'b0; tb_breq[0] = 1'b0;
    settle();
    chk("drop_busy_ss", 32'(os_ss[0]), 32'd1);
    chk("drop_busy_bgnt", 32'(ob_bgnt[0]), 32'd1);
    tick();
    rd = $urandom;
    sd_bdone[0] = 1'b1; sd_rdata[0] = rd;
    settle();
    chk("drop_rsp_bdone", 32'(ob_bdone[0]), 32'd1);
    chk("drop_rsp_rdata", ob_rdata[0], rd);
    tick();
    sd_bdone[0] = 1'b0;
    settle();
    chk("drop_grant_bgnt", 32'(ob_bgnt[0]), 32'd1);
    tick(); settle();
    chk("drop_idle_bgnt", 32'(ob_bgnt[0]), 32'd0);
    tick();

`ifdef BUS_IC_TIMEOUT_EN
    tb_breq[0] = 1'b1;
    tick();
    prio = 1;
    tick();
    tb_bstart[0] = 1'b1; tb_addr[0] = 32'h2000_0040;
    tick();
    tb_bstart[0] = 1'b0;
    cnt = 0;
    settle();
    while (!ob_berror[0] && cnt < 20) begin
      cnt++;
      tick(); settle();
    end
    chk("to_cycles", cnt, 32'd8);
    chk("to_berror", 32'(ob_berror[0]), 32'd1);
    chk("to_rdata", ob_rdata[0], 32'd0);
    tick();
    tb_bstart[0] = 1'b1; tb_addr[0] = 32'h0000_0000;
    settle();
    chk("to_next_bstart", 32'(os_bstart[0]), 32'd1);
    tick();
    tb_bstart[0] = 1'b0; sd_bdone[0] = 1'b1;
    settle();
    chk("to_next_bdone", 32'(ob_bdone[0]), 32'd1);
    tick();
    sd_bdone[0] = 1'b0; tb_breq[0] = 1'b0;
    tick(); tick();
`else
    cnt = 0;
`endif

    // randomized tenures
    for (int r = 0; r < 14; r++) do_round();
    chk("sb_empty", exp_q.size(), 32'd0);

    // reset in the middle of a transaction
    tb_breq[1] = 1'b1;
    tick();
    tick();
    tb_bstart[1] = 1'b1; tb_addr[1] = 32'h4000_0004;
    tick();
    tb_bstart[1] = 1'b0;
    settle();
    chk("rb_busy_ss", 32'(os_ss[2]), 32'd1);
    sd_bdone[2] = 1'b1; sd_rdata[2] = 32'hCAFE_F00D;
    brst_n = 1'b0;
    #1;
    chk_quiet("rst_busy");
    clear_inputs();
    brst_n = 1'b1;
    tb_breq[0] = 1'b1; tb_breq[1] = 1'b1;
    tick(); settle();
    chk("post_rst_bgnt0", 32'(ob_bgnt[0]), 32'd1);
    chk("post_rst_bgnt1", 32'(ob_bgnt[1]), 32'd0);
    clear_inputs();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
